note_scheduler: RTL and testbench



---
 rtl/note_pkg.sv | 25 ++
 rtl/note_scheduler_if.sv | 25 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/note_scheduler.sv | 165 ++++++++++++++++
 tb/tb_note_scheduler.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_pkg.sv
// Shared note-scheduler types: note codes, FSM states and timer width.
package note_pkg;

    localparam int unsigned NOTE_W  = 3;
    localparam int unsigned TIMER_W = 32;

    typedef logic [NOTE_W-1:0]  note_t;
    typedef logic [TIMER_W-1:0] timer_t;

    localparam note_t NOTE_A    = 3'd0;
    localparam note_t NOTE_B    = 3'd1;
    localparam note_t NOTE_C    = 3'd2;
    localparam note_t NOTE_D    = 3'd3;
    localparam note_t NOTE_E    = 3'd4;
    localparam note_t NOTE_F    = 3'd5;
    localparam note_t NOTE_G    = 3'd6;
    localparam note_t NOTE_REST = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/note_scheduler_if.sv
// Requester/generator bus of the note scheduler; master is the key logic side.
interface note_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    import note_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NOTE_W*NUM_REQ-1:0] req_note;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        ack;
    note_t                     note_code;
    logic                      note_valid;
    logic                      busy;

    modport master (
        output req, req_note,
        input  grant, ack, note_code, note_valid, busy
    );

    modport slave (
        input  req, req_note,
        output grant, ack, note_code, note_valid, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               valid_c
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] j;

    always_comb begin
        gnt_c   = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        sum     = '0;
        j       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            j = IDX_W'(sum);
            if (!valid_c && req[j]) begin
                valid_c  = 1'b1;
                gnt_c[j] = 1'b1;
                idx_c    = j;
            end
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// Shares one tone generator among NUM_REQ requesters: round-robin grant, timed note, silent gap.
// Optional NOTE_SCHEDULER_SUSTAIN_EN: a note extends past its minimum while its req stays high.
module note_scheduler
    import note_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned TICKS_PER_MS = 25000,
    parameter int unsigned NOTE_MS      = 250,
    parameter int unsigned GAP_MS       = 20
) (
    input  logic             clk,
    input  logic             reset,
    note_scheduler_if.slave  bus
);

    localparam int unsigned IDX_W     = $clog2(NUM_REQ);
    localparam timer_t      NOTE_LAST = TIMER_W'(NOTE_MS*TICKS_PER_MS - 1);
    localparam timer_t      GAP_LAST  = TIMER_W'(GAP_MS*TICKS_PER_MS - 1);
    localparam bit          HAS_GAP   = (GAP_MS != 0);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    timer_t             timer_q, timer_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    note_t              note_code_q, note_code_d;
    logic               note_valid_q, note_valid_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] arb_gnt_c;
    logic [IDX_W-1:0]   arb_idx_c;
    logic               arb_valid_c;
    logic [IDX_W-1:0]   next_ptr_c;
    note_t              lane_note_c [NUM_REQ];
    note_t              pick_note_c;
    logic               play_done_c;
    logic               gap_done_c;
    timer_t             play_timer_c;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (bus.req),
        .ptr     (rr_ptr_q),
        .gnt_c   (arb_gnt_c),
        .idx_c   (arb_idx_c),
        .valid_c (arb_valid_c)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            lane_note_c[i] = bus.req_note[NOTE_W*i +: NOTE_W];
        end
    end

    assign pick_note_c = lane_note_c[arb_idx_c];
    assign next_ptr_c  = (arb_idx_c == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx_c + IDX_W'(1);
    assign gap_done_c  = (timer_q == GAP_LAST);

`ifdef NOTE_SCHEDULER_SUSTAIN_EN
    // Owner index is kept so the held string can stretch the note.
    logic [IDX_W-1:0] owner_q, owner_d;

    assign play_done_c  = (timer_q >= NOTE_LAST) && !bus.req[owner_q];
    assign play_timer_c = (timer_q >= NOTE_LAST) ? timer_q : timer_q + TIMER_W'(1);

    always_comb begin
        owner_d = owner_q;
        if (state_q == IDLE && arb_valid_c) begin
            owner_d = arb_idx_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= '0;
        end else begin
            owner_q <= owner_d;
        end
    end
`else
    assign play_done_c  = (timer_q == NOTE_LAST);
    assign play_timer_c = timer_q + TIMER_W'(1);
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            timer_q      <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            note_code_q  <= '0;
            note_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            timer_q      <= timer_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            note_code_q  <= note_code_d;
            note_valid_q <= note_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (arb_valid_c) state_d = PLAY;
            PLAY: if (play_done_c) state_d = HAS_GAP ? GAP : IDLE;
            GAP:  if (gap_done_c)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output, pointer and timer next values; everything falls to zero unless a state holds it.
    always_comb begin
        grant_d      = '0;
        ack_d        = '0;
        note_code_d  = '0;
        note_valid_d = 1'b0;
        busy_d       = 1'b0;
        rr_ptr_d     = rr_ptr_q;
        timer_d      = '0;
        case (state_q)
            IDLE: begin
                if (arb_valid_c) begin
                    grant_d      = arb_gnt_c;
                    ack_d        = arb_gnt_c;
                    note_code_d  = pick_note_c;
                    note_valid_d = (pick_note_c != NOTE_REST);
                    busy_d       = 1'b1;
                    rr_ptr_d     = next_ptr_c;
                end
            end
            PLAY: begin
                if (play_done_c) begin
                    busy_d = HAS_GAP;
                end else begin
                    grant_d      = grant_q;
                    note_code_d  = note_code_q;
                    note_valid_d = note_valid_q;
                    busy_d       = 1'b1;
                    timer_d      = play_timer_c;
                end
            end
            GAP: begin
                if (!gap_done_c) begin
                    busy_d  = 1'b1;
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.grant      = grant_q;
    assign bus.ack        = ack_q;
    assign bus.note_code  = note_code_q;
    assign bus.note_valid = note_valid_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench: two schedulers (GAP_MS=1 and GAP_MS=0) against a cycle-level timeline model.
module tb_note_scheduler;
    import note_pkg::*;

    localparam int unsigned N      = 4;
    localparam int unsigned TPM    = 10;
    localparam int unsigned NMS    = 3;
    localparam int unsigned NOTE_C = NMS * TPM;
`ifdef NOTE_SCHEDULER_SUSTAIN_EN
    localparam bit SUS = 1'b1;
`else
    localparam bit SUS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [3*N-1:0] req_note = '0;
    bit             chk_on = 1'b0;
    int             n_assert = 0;
    int             n_fail = 0;

    always #5 clk = ~clk;

    note_scheduler_if #(.NUM_REQ(N)) bus_a ();
    note_scheduler_if #(.NUM_REQ(N)) bus_b ();

    assign bus_a.req      = req;
    assign bus_a.req_note = req_note;
    assign bus_b.req      = req;
    assign bus_b.req_note = req_note;

    note_scheduler #(.NUM_REQ(N), .TICKS_PER_MS(TPM), .NOTE_MS(NMS), .GAP_MS(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    note_scheduler #(.NUM_REQ(N), .TICKS_PER_MS(TPM), .NOTE_MS(NMS), .GAP_MS(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    logic [N-1:0] o_grant [2];
    logic [N-1:0] o_ack   [2];
    logic [2:0]   o_code  [2];
    logic         o_valid [2];
    logic         o_busy  [2];

    assign o_grant[0] = bus_a.grant;      assign o_grant[1] = bus_b.grant;
    assign o_ack[0]   = bus_a.ack;        assign o_ack[1]   = bus_b.ack;
    assign o_code[0]  = bus_a.note_code;  assign o_code[1]  = bus_b.note_code;
    assign o_valid[0] = bus_a.note_valid; assign o_valid[1] = bus_b.note_valid;
    assign o_busy[0]  = bus_b.busy === 1'bx ? 1'bx : bus_a.busy;
    assign o_busy[1]  = bus_b.busy;

    function automatic int unsigned gap_cyc(input int k);
        return (k == 0) ? 10 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: phase 0 idle, 1 note, 2 gap; cnt = cycles spent in the current phase.
    int unsigned m_phase [2];
    int unsigned m_cnt   [2];
    int unsigned m_ptr   [2];
    int unsigned m_owner [2];
    logic [2:0]  m_code  [2];
    bit          m_ack   [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_ack[k] = 1'b0;
            if (reset) begin
                m_phase[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0; m_owner[k] = 0; m_code[k] = '0;
            end else begin
                case (m_phase[k])
                    0: begin
                        bit found;
                        found = 1'b0;
                        for (int s = 0; s < N; s++) begin
                            int i;
                            i = (int'(m_ptr[k]) + s) % N;
                            if (!found && req[i]) begin
                                found = 1'b1;
                                m_owner[k] = i;
                                m_code[k]  = req_note[3*i +: 3];
                                m_ptr[k]   = (i + 1) % N;
                            end
                        end
                        if (found) begin
                            m_phase[k] = 1; m_cnt[k] = 1; m_ack[k] = 1'b1;
                        end
                    end
                    1: begin
                        if (m_cnt[k] >= NOTE_C && !(SUS && req[m_owner[k]])) begin
                            m_phase[k] = (gap_cyc(k) > 0) ? 2 : 0;
                            m_cnt[k]   = 1;
                        end else begin
                            m_cnt[k]++;
                        end
                    end
                    default: begin
                        if (m_cnt[k] >= gap_cyc(k)) m_phase[k] = 0;
                        else m_cnt[k]++;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                logic [N-1:0] eg;
                eg = (m_phase[k] == 1) ? N'(1) << m_owner[k] : '0;
                check($sformatf("dut%0d grant", k), 32'(o_grant[k]), 32'(eg));
                check($sformatf("dut%0d ack", k),   32'(o_ack[k]),   32'(m_ack[k] ? eg : '0));
                check($sformatf("dut%0d code", k),  32'(o_code[k]),  32'((m_phase[k] == 1) ? m_code[k] : 3'd0));
                check($sformatf("dut%0d valid", k), 32'(o_valid[k]), 32'((m_phase[k] == 1) && (m_code[k] != 3'd7)));
                check($sformatf("dut%0d busy", k),  32'(o_busy[k]),  32'(m_phase[k] != 0));
            end
        end
    end

    task automatic wait_ack(input int k);
        int c;
        c = 0;
        while (o_ack[k] == '0 && c < 400) begin
            @(negedge clk);
            c++;
        end
        if (o_ack[k] == '0) begin
            n_assert++; n_fail++;
            $display("FAIL ack timeout on dut%0d", k);
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((o_busy[0] || o_busy[1]) && c < 400) begin
            @(negedge clk);
            c++;
        end
        if (o_busy[0] || o_busy[1]) begin
            n_assert++; n_fail++;
            $display("FAIL idle timeout");
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int g;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check("reset grant", 32'(o_grant[0]), 32'd0);
        check("reset busy",  32'(o_busy[0]),  32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single request, note 2 on lane 0.
        req = 4'b0001; req_note = 12'd2;
        @(negedge clk);
        check("single grant", 32'(o_grant[0]), 32'h1);
        check("single ack",   32'(o_ack[0]),   32'h1);
        check("single code",  32'(o_code[0]),  32'd2);
        req = '0;
        n = 1; g = 0;
        while (o_valid[0] && g < 200) begin
            @(negedge clk); g++;
            if (o_valid[0]) n++;
        end
        check("single valid length", 32'(n), 32'd30);
        n = 0; g = 0;
        while (o_busy[0] && g < 200) begin
            n++; @(negedge clk); g++;
        end
        check("single gap length", 32'(n), 32'd10);
        wait_idle();

        // REST on lane 2.
        req = 4'b0100; req_note = 12'd7 << 6;
        wait_ack(0);
        req = '0;
        n = 0; g = 0;
        while (o_grant[0] == 4'b0100 && g < 200) begin
            n++;
            check("rest valid", 32'(o_valid[0]), 32'd0);
            check("rest code",  32'(o_code[0]),  32'd7);
            @(negedge clk); g++;
        end
        check("rest length", 32'(n), 32'd30);
        wait_idle();

`ifndef NOTE_SCHEDULER_SUSTAIN_EN
        // Round-robin with all lanes held.
        pulse_reset();
        req = 4'b1111; req_note = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int a = 0; a < 5; a++) begin
            logic [N-1:0] eg;
            eg = N'(1) << (a % 4);
            wait_ack(0);
            check($sformatf("rr grant %0d", a), 32'(o_grant[0]), 32'(eg));
            check($sformatf("rr code %0d", a),  32'(o_code[0]),  32'(a % 4));
            @(negedge clk);
        end
        req = '0;
        wait_idle();

        // Zero-gap instance: note, one idle cycle, next note.
        pulse_reset();
        req = 4'b0011; req_note = {6'd0, 3'd5, 3'd4};
        wait_ack(1);
        check("zgap first grant", 32'(o_grant[1]), 32'h1);
        n = 0; g = 0;
        while (o_grant[1] != '0 && g < 200) begin n++; @(negedge clk); g++; end
        check("zgap first length", 32'(n), 32'd30);
        n = 0; g = 0;
        while (!o_busy[1] && g < 200) begin n++; @(negedge clk); g++; end
        check("zgap idle length", 32'(n), 32'd1);
        check("zgap second grant", 32'(o_grant[1]), 32'h2);
        req = '0;
        n = 0; g = 0;
        while (o_grant[1] != '0 && g < 200) begin n++; @(negedge clk); g++; end
        check("zgap second length", 32'(n), 32'd30);
        wait_idle();
`else
        // Held string stretches the note to 50 cycles.
        pulse_reset();
        req = 4'b0001; req_note = 12'd4;
        wait_ack(0);
        n = 1;
        repeat (49) begin
            @(negedge clk);
            if (o_valid[0]) n++;
        end
        req = '0;
        g = 0;
        while (o_valid[0] && g < 200) begin
            @(negedge clk); g++;
            if (o_valid[0]) n++;
        end
        check("sustain length", 32'(n), 32'd50);
        wait_idle();
`endif

        // Reset mid-note restarts the pointer at lane 0.
        pulse_reset();
        req = 4'b0010; req_note = 12'd3 << 3;
        wait_ack(0);
        req = '0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset grant", 32'(o_grant[0]), 32'd0);
        check("midreset valid", 32'(o_valid[0]), 32'd0);
        check("midreset busy",  32'(o_busy[0]),  32'd0);
        check("midreset code",  32'(o_code[0]),  32'd0);
        reset = 1'b0;
        req = 4'b1010;
        @(negedge clk);
        check("post-reset grant", 32'(o_grant[0]), 32'h2);
        req = '0;
        wait_idle();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            if ($urandom_range(0, 3) == 0) req_note = 12'($urandom);
            reset = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        req = '0;
        repeat (120) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
